if_id_buffer: RTL and testbench

IF_ID_BUFFER -- requirements
Module: if_id_buffer

---
 rtl/if_id_buffer_pkg.sv | 29 ++
 rtl/if_id_buffer.sv | 138 +++++++++++++
 tb/tb_if_id_buffer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/if_id_buffer_pkg.sv
// if_id_buffer_pkg
// Shared parameters for the fetch/decode buffer: field widths, exception
// codes and the packed entry layout that moves through the buffer.

package if_id_buffer_pkg;

   localparam int PC_W       = 32;
   localparam int INS_W      = 32;
   localparam int EXC_TYPE_W = 5;

   localparam logic [EXC_TYPE_W-1:0] EXC_INT  = 5'd0;
   localparam logic [EXC_TYPE_W-1:0] EXC_ADEL = 5'd4;
   localparam logic [EXC_TYPE_W-1:0] EXC_ADES = 5'd5;
   localparam logic [EXC_TYPE_W-1:0] EXC_RI   = 5'd10;
   localparam logic [EXC_TYPE_W-1:0] EXC_OV   = 5'd12;

   // One buffer entry. All six fields are stored and read back as one word.
   typedef struct packed {
      logic [PC_W-1:0]       pc;
      logic [INS_W-1:0]      ins;
      logic                  exc;
      logic [EXC_TYPE_W-1:0] exc_type;
      logic                  eret;
      logic                  bd;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/if_id_buffer.sv
// if_id_buffer
// Small in-order queue between instruction fetch and decode. Once an entry
// carrying a fetch exception or an eret is accepted, the buffer locks and
// refuses further pushes (they are wrong-path) until a flush arrives.
//
// Ports
//   clk, rst_n              clock, async-assert active-low reset
//   flush                   drop all entries and leave LOCK
//   in_valid / in_ready     push handshake from fetch
//   in_pc .. in_bd          fields of the pushed entry
//   out_valid / out_ready   pop handshake to decode
//   out_pc .. out_bd        head entry fields (all zero when empty)
//   count                   number of occupied entries
//
// state | meaning
// RUN   | accepting pushes while not full
// LOCK  | exception/eret entry accepted; pushes blocked, pops continue

module if_id_buffer
   import if_id_buffer_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [PC_W-1:0]       in_pc,
   input  logic [INS_W-1:0]      in_ins,
   input  logic                  in_exc,
   input  logic [EXC_TYPE_W-1:0] in_exc_type,
   input  logic                  in_eret,
   input  logic                  in_bd,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [PC_W-1:0]       out_pc,
   output logic [INS_W-1:0]      out_ins,
   output logic                  out_exc,
   output logic [EXC_TYPE_W-1:0] out_exc_type,
   output logic                  out_eret,
   output logic                  out_bd,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {
      RUN  = 1'b0,
      LOCK = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   // Cleared by reset and set on the first edge afterwards, so in_ready
   // stays low until reset has been released synchronously.
   logic               live_q, live_d;
   entry_t             mem_q [DEPTH];

   entry_t             in_entry;
   entry_t             out_entry;
   logic               push;
   logic               pop;

   assign in_entry = '{pc: in_pc, ins: in_ins, exc: in_exc,
                       exc_type: in_exc_type, eret: in_eret, bd: in_bd};

   assign in_ready  = live_q & (count_q < CNT_W'(DEPTH)) & (state_q == RUN) & ~flush;
   assign out_valid = (count_q != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      live_d   = 1'b1;
      if (flush) begin
         state_d  = RUN;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (in_exc | in_eret) begin
               state_d = LOCK;
            end
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= RUN;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         live_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         live_q   <= live_d;
      end
   end

   // Storage is not reset; count gating of the outputs hides stale words.
   // push is already low during flush because in_ready includes ~flush.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_entry;
      end
   end

   assign out_entry    = out_valid ? mem_q[rd_ptr_q] : '0;
   assign out_pc       = out_entry.pc;
   assign out_ins      = out_entry.ins;
   assign out_exc      = out_entry.exc;
   assign out_exc_type = out_entry.exc_type;
   assign out_eret     = out_entry.eret;
   assign out_bd       = out_entry.bd;
   assign count        = count_q;

endmodule

// File: tb/tb_if_id_buffer.sv
module tb_if_id_buffer;
   import if_id_buffer_pkg::*;

   localparam int DEPTH = 2;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  flush = 1'b0;
   logic                  in_valid = 1'b0;
   logic                  in_ready;
   logic [PC_W-1:0]       in_pc = '0;
   logic [INS_W-1:0]      in_ins = '0;
   logic                  in_exc = 1'b0;
   logic [EXC_TYPE_W-1:0] in_exc_type = '0;
   logic                  in_eret = 1'b0;
   logic                  in_bd = 1'b0;
   logic                  out_valid;
   logic                  out_ready = 1'b0;
   logic [PC_W-1:0]       out_pc;
   logic [INS_W-1:0]      out_ins;
   logic                  out_exc;
   logic [EXC_TYPE_W-1:0] out_exc_type;
   logic                  out_eret;
   logic                  out_bd;
   logic [CNT_W-1:0]      count;

   if_id_buffer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_ins(in_ins), .in_exc(in_exc),
      .in_exc_type(in_exc_type), .in_eret(in_eret), .in_bd(in_bd),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_ins(out_ins), .out_exc(out_exc),
      .out_exc_type(out_exc_type), .out_eret(out_eret), .out_bd(out_bd),
      .count(count)
   );

   always #5 clk = ~clk;

   int     n_vec = 0;
   int     n_err = 0;
   entry_t sb_q[$];
   int     m_cnt = 0;
   bit     m_lock = 1'b0;
   bit     m_live = 1'b0;

   task automatic chk(input string tag, input logic [ENTRY_W-1:0] obs,
                      input logic [ENTRY_W-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic entry_t dut_head();
      entry_t e;
      e = '{pc: out_pc, ins: out_ins, exc: out_exc, exc_type: out_exc_type,
            eret: out_eret, bd: out_bd};
      return e;
   endfunction

   function automatic entry_t mk(input logic [31:0] pc, input logic [31:0] ins,
                                 input logic exc, input logic [4:0] et,
                                 input logic eret, input logic bd);
      entry_t e;
      e = '{pc: pc, ins: ins, exc: exc, exc_type: et, eret: eret, bd: bd};
      return e;
   endfunction

   // Drive one cycle's inputs, check the DUT against the model before the
   // edge, then advance the model across the edge.
   task automatic step(input string tag, input logic v, input entry_t e,
                       input logic ordy, input logic fl);
      bit exp_rdy, do_push, do_pop;
      in_valid    = v;
      in_pc       = e.pc;
      in_ins      = e.ins;
      in_exc      = e.exc;
      in_exc_type = e.exc_type;
      in_eret     = e.eret;
      in_bd       = e.bd;
      out_ready   = ordy;
      flush       = fl;
      #1;
      exp_rdy = m_live && (m_cnt < DEPTH) && !m_lock && !fl;
      chk({tag, ".in_ready"}, ENTRY_W'(in_ready), ENTRY_W'(exp_rdy));
      chk({tag, ".count"}, ENTRY_W'(count), ENTRY_W'(m_cnt));
      chk({tag, ".out_valid"}, ENTRY_W'(out_valid), ENTRY_W'(m_cnt != 0));
      if (m_cnt != 0) chk({tag, ".head"}, dut_head(), sb_q[0]);
      else            chk({tag, ".empty_out"}, dut_head(), '0);
      do_push = v && exp_rdy;
      do_pop  = ordy && (m_cnt != 0);
      @(posedge clk);
      #1;
      m_live = 1'b1;
      if (fl) begin
         sb_q.delete();
         m_cnt  = 0;
         m_lock = 1'b0;
      end else begin
         if (do_pop) begin
            void'(sb_q.pop_front());
            m_cnt--;
         end
         if (do_push) begin
            sb_q.push_back(e);
            m_cnt++;
            if (e.exc || e.eret) m_lock = 1'b1;
         end
      end
   endtask

   entry_t nop;
   entry_t r;

   initial begin
      nop = '0;

      // reset state while rst_n is held low
      #2;
      chk("rst.count", ENTRY_W'(count), '0);
      chk("rst.out_valid", ENTRY_W'(out_valid), '0);
      chk("rst.in_ready", ENTRY_W'(in_ready), '0);
      chk("rst.out", dut_head(), '0);

      // release between edges; in_ready must wait for the next edge
      @(negedge clk);
      rst_n = 1'b1;
      step("rel0", 1'b0, nop, 1'b0, 1'b0);
      step("rel1", 1'b0, nop, 1'b0, 1'b0);

      // single push then pop, one-cycle latency, no bypass
      step("one.push", 1'b1, mk(32'h3000, 32'h2401_0001, 0, 0, 0, 0), 1'b1, 1'b0);
      step("one.pop",  1'b0, nop, 1'b1, 1'b0);
      step("one.idle", 1'b0, nop, 1'b1, 1'b0);

      // fill to DEPTH, third push refused, drain in order
      step("fill0", 1'b1, mk(32'h3000, 32'h1, 0, 0, 0, 0), 1'b0, 1'b0);
      step("fill1", 1'b1, mk(32'h3004, 32'h2, 0, 0, 0, 1), 1'b0, 1'b0);
      step("fill2", 1'b1, mk(32'h3008, 32'h3, 0, 0, 0, 0), 1'b0, 1'b0);
      step("drain0", 1'b0, nop, 1'b1, 1'b0);
      step("drain1", 1'b0, nop, 1'b1, 1'b0);
      step("drain2", 1'b0, nop, 1'b1, 1'b0);

      // exception entry locks the buffer until flush
      step("exc.push", 1'b1, mk(32'h3001, 32'h0, 1, EXC_ADEL, 0, 0), 1'b0, 1'b0);
      step("exc.lock", 1'b1, mk(32'h3100, 32'h5, 0, 0, 0, 0), 1'b0, 1'b0);
      step("exc.flush", 1'b1, mk(32'h3104, 32'h6, 0, 0, 0, 0), 1'b0, 1'b1);
      step("exc.after", 1'b0, nop, 1'b0, 1'b0);

      // eret locks; pops continue in LOCK; exc push in flush cycle dropped
      step("eret.push", 1'b1, mk(32'h4000, 32'h4200_0018, 0, 0, 1, 0), 1'b0, 1'b0);
      step("eret.hold0", 1'b1, mk(32'h4004, 32'h7, 0, 0, 0, 0), 1'b0, 1'b0);
      step("eret.pop", 1'b1, mk(32'h4008, 32'h8, 0, 0, 0, 0), 1'b1, 1'b0);
      step("eret.hold1", 1'b1, mk(32'h400c, 32'h9, 0, 0, 0, 0), 1'b0, 1'b0);
      step("eret.flush", 1'b1, mk(32'h4010, 32'ha, 1, EXC_RI, 1, 0), 1'b0, 1'b1);
      step("eret.run", 1'b0, nop, 1'b0, 1'b0);

      // flush beats simultaneous push and pop
      step("fpp.push", 1'b1, mk(32'h5000, 32'hb, 0, 0, 0, 0), 1'b0, 1'b0);
      step("fpp.all", 1'b1, mk(32'h5004, 32'hc, 0, 0, 0, 0), 1'b1, 1'b1);
      step("fpp.after", 1'b0, nop, 1'b0, 1'b0);

      // random traffic exercises pointer wrap and push+pop in one cycle
      for (int i = 0; i < 40; i++) begin
         r = mk($urandom, $urandom, 1'b0, 5'($urandom), 1'b0, 1'($urandom));
         step("rand", 1'($urandom), r, 1'($urandom_range(0, 3) != 0), 1'b0);
      end
      step("rand.flush", 1'b0, nop, 1'b0, 1'b1);

      // asynchronous reset between edges with two entries stored
      step("ar.push0", 1'b1, mk(32'h6000, 32'hd, 0, 0, 0, 0), 1'b0, 1'b0);
      step("ar.push1", 1'b1, mk(32'h6004, 32'he, 0, 0, 0, 1), 1'b0, 1'b0);
      chk("ar.count_before", ENTRY_W'(count), ENTRY_W'(2));
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar.out_valid", ENTRY_W'(out_valid), '0);
      chk("ar.out", dut_head(), '0);
      chk("ar.count", ENTRY_W'(count), '0);
      chk("ar.in_ready", ENTRY_W'(in_ready), '0);
      sb_q.delete();
      m_cnt  = 0;
      m_lock = 1'b0;
      m_live = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step("ar.rel0", 1'b0, nop, 1'b0, 1'b0);
      step("ar.rel1", 1'b1, mk(32'h7000, 32'hf, 0, 0, 0, 0), 1'b1, 1'b0);
      step("ar.rel2", 1'b0, nop, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
